// File: rtl/doodle_pkg.sv
// Shared constants for the doodle-jump playfield: screen geometry, sprite sizes,
// platform-field FSM encodings and the power-on platform layout.
package doodle_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int PLAT_W   = 64;
    localparam int PLAT_H   = 8;
    localparam int NUM_PLAT = 6;
    localparam int DOODLE_W = 40;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCROLL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // Staggered columns so the initial ladder zig-zags across the screen.
    function automatic logic [9:0] reset_px(input int idx);
        case (idx % 6)
            0:       return 10'd288;
            1:       return 10'd96;
            2:       return 10'd480;
            3:       return 10'd192;
            4:       return 10'd384;
            default: return 10'd32;
        endcase
    endfunction

    function automatic logic [9:0] reset_py(input int idx);
        return 10'(440 - 80 * idx);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only when stepped.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        step,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            value <= SEED;
        end else if (step) begin
            value <= {feedback, value[15:1]};
        end
    end

endmodule

// File: rtl/platform_field.sv
// Scrolling platform field: per-frame scroll/respawn, sequential landing scan,
// and a registered per-pixel platform mask for the VGA renderer.
module platform_field
    import doodle_pkg::*;
#(
    parameter int          NUM_PLAT  = doodle_pkg::NUM_PLAT,
    parameter int          PLAT_W    = doodle_pkg::PLAT_W,
    parameter int          PLAT_H    = doodle_pkg::PLAT_H,
    parameter int          DOODLE_W  = doodle_pkg::DOODLE_W,
    parameter int          H_RES     = doodle_pkg::H_RES,
    parameter int          V_RES     = doodle_pkg::V_RES,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [3:0] scroll_amt,
    input  logic       falling,
    input  logic [9:0] doodle_x,
    input  logic [9:0] doodle_y,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       plat_pixel,
    output logic       landed,
    output logic [9:0] land_y,
    output logic       busy,
    output logic       overrun
);

    localparam int IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

    logic [1:0]       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [9:0]       px_reg [NUM_PLAT];
    logic [9:0]       py_reg [NUM_PLAT];

    logic [3:0]       scroll_reg;
    logic             falling_reg;
    logic [9:0]       dx_reg;
    logic [9:0]       dy_reg;

    logic             hit_reg;
    logic [9:0]       hit_y_reg;
    logic             busy_reg;
    logic             landed_reg;
    logic [9:0]       land_y_reg;
    logic             overrun_reg;
    logic             pixel_reg;

    logic [15:0]      lfsr_value;
    logic [9:0]       spawn_px;
    logic             unused_lfsr_bits;

    logic [10:0]         sum_y     [NUM_PLAT];
    logic [9:0]          wrapped_y [NUM_PLAT];
    logic [NUM_PLAT-1:0] respawn;
    logic [NUM_PLAT-1:0] on_plat;

    logic [9:0]       sel_px;
    logic [9:0]       sel_py;
    logic             slot_hit;
    logic             accept;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (state_reg == ST_SCROLL),
        .value (lfsr_value)
    );

    assign spawn_px         = {1'b0, lfsr_value[8:0]} + 10'd32;
    assign unused_lfsr_bits = ^lfsr_value[15:9];

    // Ticks are only taken once the busy flag the outside world sees has dropped.
    assign accept = frame_tick && (state_reg == ST_IDLE) && !busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAT; gi++) begin : g_slot
            assign sum_y[gi]     = {1'b0, py_reg[gi]} + {7'd0, scroll_reg};
            assign respawn[gi]   = sum_y[gi] >= 11'(V_RES);
            assign wrapped_y[gi] = 10'(sum_y[gi] - 11'(V_RES));
            assign on_plat[gi]   = ({1'b0, hCount} >= {1'b0, px_reg[gi]}) &&
                                   ({1'b0, hCount} <  {1'b0, px_reg[gi]} + 11'(PLAT_W)) &&
                                   ({1'b0, vCount} >= {1'b0, py_reg[gi]}) &&
                                   ({1'b0, vCount} <  {1'b0, py_reg[gi]} + 11'(PLAT_H));
        end
    endgenerate

    always_comb begin
        sel_px = '0;
        sel_py = '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sel_px = px_reg[i];
                sel_py = py_reg[i];
            end
        end
    end

    assign slot_hit = falling_reg &&
                      ({1'b0, dx_reg} + 11'(DOODLE_W) >  {1'b0, sel_px}) &&
                      ({1'b0, dx_reg}                 <  {1'b0, sel_px} + 11'(PLAT_W)) &&
                      ({1'b0, dy_reg}                 >= {1'b0, sel_py}) &&
                      ({1'b0, dy_reg}                 <  {1'b0, sel_py} + 11'(PLAT_H));

    // Every respawning slot in one scroll shares the same LFSR draw.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                px_reg[i] <= reset_px(i);
                py_reg[i] <= reset_py(i);
            end
        end else if (state_reg == ST_SCROLL) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                if (respawn[i]) begin
                    py_reg[i] <= wrapped_y[i];
                    px_reg[i] <= spawn_px;
                end else begin
                    py_reg[i] <= sum_y[i][9:0];
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            scroll_reg  <= '0;
            falling_reg <= 1'b0;
            dx_reg      <= '0;
            dy_reg      <= '0;
            hit_reg     <= 1'b0;
            hit_y_reg   <= '0;
            busy_reg    <= 1'b0;
            landed_reg  <= 1'b0;
            land_y_reg  <= '0;
            overrun_reg <= 1'b0;
            pixel_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg   <= ST_SCROLL;
                        scroll_reg  <= scroll_amt;
                        falling_reg <= falling;
                        dx_reg      <= doodle_x;
                        dy_reg      <= doodle_y;
                    end
                end
                ST_SCROLL: begin
                    state_reg <= ST_SCAN;
                    idx_reg   <= '0;
                    hit_reg   <= 1'b0;
                    hit_y_reg <= '0;
                end
                ST_SCAN: begin
                    if (slot_hit && !hit_reg) begin
                        hit_reg   <= 1'b1;
                        hit_y_reg <= sel_py;
                    end
                    if (idx_reg == IDX_W'(NUM_PLAT - 1)) begin
                        state_reg <= ST_REPORT;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            busy_reg   <= (state_reg != ST_IDLE);
            landed_reg <= (state_reg == ST_REPORT) && hit_reg;
            land_y_reg <= ((state_reg == ST_REPORT) && hit_reg) ? hit_y_reg : 10'd0;
            if (frame_tick && !accept) begin
                overrun_reg <= 1'b1;
            end
            pixel_reg <= (|on_plat) && ({1'b0, hCount} < 11'(H_RES));
        end
    end

    assign plat_pixel = pixel_reg;
    assign landed     = landed_reg;
    assign land_y     = land_y_reg;
    assign busy       = busy_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_platform_field.sv
// Bench for platform_field: frame-timeline reference model checked every cycle,
// plus directed literal checks on reset layout, landing, overrun and mid-update reset.
module tb_platform_field;

    localparam int NP = 6;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] scroll_amt = '0;
    logic       falling = 1'b0;
    logic [9:0] doodle_x = '0;
    logic [9:0] doodle_y = '0;
    logic [9:0] hCount = '0;
    logic [9:0] vCount = '0;
    logic       plat_pixel;
    logic       landed;
    logic [9:0] land_y;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    bit sweep_en = 1'b0;
    int frame_no = 0;

    platform_field dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .scroll_amt (scroll_amt),
        .falling    (falling),
        .doodle_x   (doodle_x),
        .doodle_y   (doodle_y),
        .hCount     (hCount),
        .vCount     (vCount),
        .plat_pixel (plat_pixel),
        .landed     (landed),
        .land_y     (land_y),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial forever #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame timeline ----------------
    int          m_px [NP];
    int          m_py [NP];
    logic [15:0] m_lfsr;
    bit          m_active;
    int          m_j;
    bit          m_hit;
    int          m_hit_y;
    int          c_scroll;
    bit          c_fall;
    int          c_x;
    int          c_y;
    bit          e_pix;
    bit          e_busy;
    bit          e_landed;
    bit          e_overrun;
    int          e_land_y;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_px = '{288, 96, 480, 192, 384, 32};
            for (int i = 0; i < NP; i++) m_py[i] = 440 - 80 * i;
            m_lfsr = 16'hACE1;
            m_active = 0; m_j = 0; m_hit = 0; m_hit_y = 0;
            e_pix = 0; e_busy = 0; e_landed = 0; e_overrun = 0; e_land_y = 0;
        end else begin
            bit was_active;
            e_pix = 0;
            for (int i = 0; i < NP; i++)
                if (int'(hCount) >= m_px[i] && int'(hCount) < m_px[i] + 64 &&
                    int'(vCount) >= m_py[i] && int'(vCount) < m_py[i] + 8)
                    e_pix = 1;
            was_active = m_active;
            if (was_active) begin
                m_j++;
                if (m_j == 1) begin
                    for (int i = 0; i < NP; i++) begin
                        int s;
                        s = m_py[i] + c_scroll;
                        if (s >= 480) begin
                            m_py[i] = s - 480;
                            m_px[i] = int'(m_lfsr[8:0]) + 32;
                        end else begin
                            m_py[i] = s;
                        end
                    end
                    m_lfsr = lfsr_next(m_lfsr);
                    m_hit = 0;
                    m_hit_y = 0;
                    for (int i = 0; i < NP; i++)
                        if (!m_hit && c_fall && c_x + 40 > m_px[i] && c_x < m_px[i] + 64 &&
                            m_py[i] <= c_y && c_y < m_py[i] + 8) begin
                            m_hit = 1;
                            m_hit_y = m_py[i];
                        end
                end
                if (m_j == 9) m_active = 0;
            end
            if (frame_tick) begin
                if (was_active) e_overrun = 1;
                else begin
                    m_active = 1; m_j = 0;
                    c_scroll = int'(scroll_amt); c_fall = falling;
                    c_x = int'(doodle_x); c_y = int'(doodle_y);
                end
            end
            e_busy   = m_active && m_j >= 1 && m_j <= 8;
            e_landed = m_active && m_j == 8 && m_hit;
            e_land_y = e_landed ? m_hit_y : 0;
        end
    end

    always @(negedge Clk) begin
        check("plat_pixel", 32'(plat_pixel), 32'(e_pix));
        check("busy",       32'(busy),       32'(e_busy));
        check("landed",     32'(landed),     32'(e_landed));
        check("land_y",     32'(land_y),     32'(e_land_y));
        check("overrun",    32'(overrun),    32'(e_overrun));
    end

    // Pixel sweep biased towards platform edges.
    always @(posedge Clk) begin
        #1;
        if (sweep_en) begin
            int s, h, v;
            s = int'($urandom_range(0, NP - 1));
            h = m_px[s] + int'($urandom_range(0, 80)) - 8;
            v = m_py[s] + int'($urandom_range(0, 12)) - 2;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            hCount = 10'(h);
            vCount = 10'(v);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame(input int s, input bit f, input int x, input int y);
        frame_no++;
        $display("frame %0d: scroll=%0d falling=%0d doodle=(%0d,%0d)", frame_no, s, f, x, y);
        scroll_amt = 4'(s); falling = f; doodle_x = 10'(x); doodle_y = 10'(y);
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;
        step(1);
    endtask

    task automatic check_reset_layout(input string tag);
        int rpx [NP];
        rpx = '{288, 96, 480, 192, 384, 32};
        for (int i = 0; i < NP; i++) begin
            check({tag, "_px"}, 32'(dut.px_reg[i]), 32'(rpx[i]));
            check({tag, "_py"}, 32'(dut.py_reg[i]), 32'(440 - 80 * i));
        end
        check({tag, "_lfsr"}, 32'(dut.u_lfsr.value), 32'h0000ACE1);
    endtask

    initial begin
        #1 Reset = 1'b1;
        step(3);
        Reset = 1'b0;
        step(1);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check_reset_layout("rst");

        // pixel probe at the reset layout
        hCount = 10'd300; vCount = 10'd441;
        step(1);
        check("pix_in", 32'(plat_pixel), 1);
        hCount = 10'd352;
        step(1);
        check("pix_edge", 32'(plat_pixel), 0);

        // landing on slot 0 with no scroll
        frame(0, 1, 300, 440);
        step(1);
        check("land_busy_t1", 32'(busy), 1);
        step(6);
        check("land_early", 32'(landed), 0);
        step(1);
        check("land_t8", 32'(landed), 1);
        check("land_y_t8", 32'(land_y), 440);
        step(1);
        check("land_t9", 32'(landed), 0);
        check("busy_t9", 32'(busy), 0);
        check("slot0_py", 32'(dut.py_reg[0]), 440);
        check("slot0_px", 32'(dut.px_reg[0]), 288);
        check("lfsr_step1", 32'(dut.u_lfsr.value), 32'h00005670);
        step(3);

        // not falling: never lands
        frame(0, 0, 300, 440);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            check("nofall_landed", 32'(landed), 0);
            check("nofall_busy", 32'(busy), (k <= 8) ? 1 : 0);
        end
        step(3);

        // ten scrolling frames, slot 0 wraps
        do_reset();
        sweep_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            frame(5, 0, 0, 0);
            step(11);
        end
        check("model_py0", 32'(m_py[0]), 10);
        check("model_py1", 32'(m_py[1]), 410);
        check("model_py5", 32'(m_py[5]), 90);
        for (int i = 0; i < NP; i++) begin
            check("scroll_px", 32'(dut.px_reg[i]), 32'(m_px[i]));
            check("scroll_py", 32'(dut.py_reg[i]), 32'(m_py[i]));
        end
        check("scroll_lfsr", 32'(dut.u_lfsr.value), 32'(m_lfsr));

        // overrun: second tick at T+3 is dropped
        sweep_en = 1'b0;
        do_reset();
        frame(0, 1, 300, 440);
        step(2);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("ovr_set", 32'(overrun), 1);
        step(5);
        check("ovr_land_t8", 32'(landed), 1);
        check("ovr_land_y", 32'(land_y), 440);
        step(1);
        check("ovr_land_t9", 32'(landed), 0);
        step(10);
        check("ovr_sticky", 32'(overrun), 1);

        // random frames aimed at platforms
        sweep_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int s, sc, y;
            s  = int'($urandom_range(0, NP - 1));
            sc = int'($urandom_range(0, 15));
            y  = m_py[s] + sc + int'($urandom_range(0, 9));
            if (y > 1023) y = 1023;
            frame(sc, ($urandom_range(0, 3) != 0), m_px[s] + int'($urandom_range(0, 100)) - 40 < 0 ? 0 :
                  m_px[s] + int'($urandom_range(0, 100)) - 40, y);
            step(10);
        end

        // reset in the middle of an update
        sweep_en = 1'b0;
        frame(5, 1, 300, 440);
        step(3);
        Reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_landed", 32'(landed), 0);
        check("mid_overrun", 32'(overrun), 0);
        check("mid_pixel", 32'(plat_pixel), 0);
        check_reset_layout("mid");
        step(2);
        Reset = 1'b0;
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
